// File: rtl/hs32_regarb_pkg.sv
// Shared types and defaults for the hs32 register-file arbiter.
// FSM state encoding and the 2-way write picker used by hs32_arb2.
package hs32_regarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int STARVE_MAX_DEF = 3;
    localparam int AW_DEF         = 4;
    localparam int DW_DEF         = 32;

    // One-hot grant for two requesters; prefer1 breaks a tie towards requester 1.
    function automatic logic [1:0] pick2(input logic [1:0] req, input logic prefer1);
        logic [1:0] g;
        g[0] = req[0] & (~req[1] | ~prefer1);
        g[1] = req[1] & (~req[0] | prefer1);
        return g;
    endfunction

endpackage

// File: rtl/hs32_arb2.sv
// Two-requester write picker with one-hot grant.
// HS32_REGARB_RR_EN selects round-robin; otherwise requester 0 always wins a tie.
module hs32_arb2
    import hs32_regarb_pkg::*;
(
`ifdef HS32_REGARB_RR_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef HS32_REGARB_RR_EN
    // rr_last = 1 means requester 1 won last, so requester 0 gets the next tie.
    logic rr_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last <= 1'b1;
        end else if (|gnt) begin
            rr_last <= gnt[1];
        end
    end

    assign gnt = pick2(req, ~rr_last);
`else
    assign gnt = pick2(req, 1'b0);
`endif

endmodule

// File: rtl/hs32_regarb.sv
// Schedules the single-port-write register file between two writeback ports and one operand read.
// Optional round-robin write arbitration: define HS32_REGARB_RR_EN.
//
// state | meaning
// IDLE  | no read outstanding; a read may be accepted
// CAPT  | register file is presenting read data; writes blocked
// HOLD  | response valid, waiting for rsp_ready; writes allowed
module hs32_regarb
    import hs32_regarb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr0_valid,
    output logic          wr0_ready,
    input  logic [AW-1:0] wr0_adr,
    input  logic [DW-1:0] wr0_data,
    input  logic          wr1_valid,
    output logic          wr1_ready,
    input  logic [AW-1:0] wr1_adr,
    input  logic [DW-1:0] wr1_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_adr1,
    input  logic [AW-1:0] rd_adr2,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data1,
    output logic [DW-1:0] rsp_data2,
    output logic          rf_we,
    output logic [AW-1:0] rf_wadr,
    output logic [DW-1:0] rf_din,
    output logic [AW-1:0] rf_radr1,
    output logic [AW-1:0] rf_radr2,
    input  logic [DW-1:0] rf_dout1,
    input  logic [DW-1:0] rf_dout2
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          is_idle;
    logic          force_rd;
    logic [1:0]    wr_req;
    logic [1:0]    gnt;
    logic          wr_any;
    logic          rd_acc;

    assign is_idle  = (state == ST_IDLE);
    assign force_rd = is_idle & rd_valid & (starve_cnt == STARVE_TOP);

    // Writes are held off while read data is being captured or a starved read is forced.
    assign wr_req = {wr1_valid, wr0_valid} & {2{(state != ST_CAPT) & ~force_rd}};

    hs32_arb2 u_arb2 (
`ifdef HS32_REGARB_RR_EN
        .clk   (clk),
        .reset (reset),
`endif
        .req   (wr_req),
        .gnt   (gnt)
    );

    assign wr_any = |gnt;
    assign rd_acc = is_idle & rd_valid & ~wr_any;

    // Reset gating lives only on the outputs so no flop D-path depends on reset.
    always_comb begin
        wr0_ready = 1'b0;
        wr1_ready = 1'b0;
        rd_ready  = 1'b0;
        rf_we     = 1'b0;
        rf_wadr   = '0;
        rf_din    = '0;
        rf_radr1  = '0;
        rf_radr2  = '0;
        if (reset) begin
            wr0_ready = gnt[0];
            wr1_ready = gnt[1];
            rd_ready  = rd_acc;
            rf_we     = wr_any;
            rf_radr1  = rd_adr1;
            rf_radr2  = rd_adr2;
            if (gnt[1]) begin
                rf_wadr = wr1_adr;
                rf_din  = wr1_data;
            end else if (gnt[0]) begin
                rf_wadr = wr0_adr;
                rf_din  = wr0_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rd_acc) state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_HOLD;
            ST_HOLD: if (rsp_valid && rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (rd_acc) begin
            starve_cnt <= '0;
        end else if (is_idle && rd_valid && wr_any && (starve_cnt != STARVE_TOP)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end else if (state == ST_CAPT) begin
            rsp_valid <= 1'b1;
            rsp_data1 <= rf_dout1;
            rsp_data2 <= rf_dout2;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
